// File: rtl/ddr3_port_arbiter.sv
// Two-master Avalon-MM burst arbiter in front of the DDR3 EMIF slave port.
// Round-robin with camera urgent override at burst boundaries; read beats return via a tag FIFO.
module ddr3_port_arbiter #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 64,
  parameter int BURST_W    = 4,
  parameter int PEND_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [BURST_W-1:0]    m0_burstcount,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic                  m0_urgent,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [BURST_W-1:0]    m1_burstcount,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [BURST_W-1:0]    s_burstcount,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_readdatavalid,

  output logic [1:0]            grant_id,
  output logic                  rsp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(PEND_DEPTH);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state_q, state_d;
  logic                 gnt_q, gnt_d;
  logic                 last_q, last_d;
  logic [BURST_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [BURST_W-1:0]   wr_len_q, wr_len_d;

  // Granted master's command, selected by the registered grant.
  logic [ADDR_W-1:0]    g_address;
  logic                 g_read;
  logic                 g_write;
  logic [BURST_W-1:0]   g_burstcount;
  logic [DATA_W-1:0]    g_writedata;
  logic [BE_W-1:0]      g_byteenable;
  logic [BURST_W-1:0]   g_len;
  logic [BURST_W-1:0]   wr_len_now;
  logic                 g_wait;

  logic                 req0, req1, winner;

  // Pending-read tag FIFO
  logic                 tag_id  [PEND_DEPTH];
  logic [BURST_W-1:0]   tag_len [PEND_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       cnt_q;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop;

  logic                 head_id;
  logic [BURST_W-1:0]   head_len;
  logic [BURST_W-1:0]   rsp_cnt_q;
  logic                 rsp_fire;

  assign g_address    = gnt_q ? m1_address    : m0_address;
  assign g_read       = gnt_q ? m1_read       : m0_read;
  assign g_write      = gnt_q ? m1_write      : m0_write;
  assign g_burstcount = gnt_q ? m1_burstcount : m0_burstcount;
  assign g_writedata  = gnt_q ? m1_writedata  : m0_writedata;
  assign g_byteenable = gnt_q ? m1_byteenable : m0_byteenable;

  // A burstcount of zero is a single beat.
  assign g_len      = (g_burstcount == '0) ? BURST_W'(1) : g_burstcount;
  assign wr_len_now = (wr_cnt_q == '0) ? g_len : wr_len_q;

  assign fifo_full  = (cnt_q == FULL_CNT);
  assign fifo_empty = (cnt_q == '0);

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Urgent camera wins outright; a tie goes to whoever was not granted last.
  always_comb begin
    if (m0_urgent && req0)  winner = 1'b0;
    else if (req0 && req1)  winner = ~last_q;
    else                    winner = ~req0;
  end

  assign g_wait = s_waitrequest | (g_read & fifo_full);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    last_d         = last_q;
    wr_cnt_d       = wr_cnt_q;
    wr_len_d       = wr_len_q;
    push           = 1'b0;
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_burstcount   = '0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = winner;
          last_d  = winner;
          state_d = GRANT;
        end
      end

      GRANT: begin
        s_address    = g_address;
        s_burstcount = g_burstcount;
        s_writedata  = g_writedata;
        s_byteenable = g_byteenable;
        s_read       = g_read & ~fifo_full;
        s_write      = g_write;
        if (gnt_q) m1_waitrequest = g_wait;
        else       m0_waitrequest = g_wait;

        if (g_read && !fifo_full && !s_waitrequest) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (g_write && !s_waitrequest) begin
          if (wr_cnt_q == '0) wr_len_d = g_len;
          if (wr_cnt_q + BURST_W'(1) == wr_len_now) begin
            wr_cnt_d = '0;
            state_d  = IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + BURST_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;  // first tie after reset goes to the camera
      wr_cnt_q <= '0;
      wr_len_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      wr_cnt_q <= wr_cnt_d;
      wr_len_q <= wr_len_d;
    end
  end

  assign grant_id = {state_q == GRANT, gnt_q};

  // NOTE: tag storage has no reset; pointers and count define validity, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_id[wr_ptr_q]  <= gnt_q;
      tag_len[wr_ptr_q] <= g_len;
    end
  end

  assign head_id  = tag_id[rd_ptr_q];
  assign head_len = tag_len[rd_ptr_q];

  assign rsp_fire = s_readdatavalid & ~fifo_empty;
  assign pop      = rsp_fire & (rsp_cnt_q + BURST_W'(1) == head_len);

  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = rsp_fire & ~head_id;
  assign m1_readdatavalid = rsp_fire &  head_id;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Response beat counter and the sticky orphan-beat flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_cnt_q <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (pop)           rsp_cnt_q <= '0;
      else if (rsp_fire) rsp_cnt_q <= rsp_cnt_q + BURST_W'(1);
      if (s_readdatavalid && fifo_empty) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Randomized scoreboard bench for ddr3_port_arbiter: bench-side masters and EMIF slave,
// transaction-level reference model, and a separate monitor that pops expectations.
module tb_ddr3_port_arbiter;

  localparam int ADDR_W     = 27;
  localparam int DATA_W     = 64;
  localparam int BURST_W    = 4;
  localparam int PEND_DEPTH = 8;
  localparam int BE_W       = DATA_W / 8;

  logic                clk, reset;
  logic [ADDR_W-1:0]   m0_address, m1_address;
  logic                m0_read, m0_write, m1_read, m1_write;
  logic [BURST_W-1:0]  m0_burstcount, m1_burstcount;
  logic [DATA_W-1:0]   m0_writedata, m1_writedata;
  logic [BE_W-1:0]     m0_byteenable, m1_byteenable;
  logic                m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0]   m0_readdata, m1_readdata;
  logic                m0_readdatavalid, m1_readdatavalid;
  logic                m0_urgent;
  logic [ADDR_W-1:0]   s_address;
  logic                s_read, s_write;
  logic [BURST_W-1:0]  s_burstcount;
  logic [DATA_W-1:0]   s_writedata;
  logic [BE_W-1:0]     s_byteenable;
  logic                s_waitrequest;
  logic [DATA_W-1:0]   s_readdata;
  logic                s_readdatavalid;
  logic [1:0]          grant_id;
  logic                rsp_err;

  ddr3_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .PEND_DEPTH(PEND_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m0_urgent(m0_urgent),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_burstcount(m1_burstcount), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_burstcount(s_burstcount),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .grant_id(grant_id), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic               wr;
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] bc;
    logic [DATA_W-1:0]  wd;
    logic [BE_W-1:0]    be;
  } cmd_t;

  // Scoreboard queues
  cmd_t               exp_cmd[$];
  logic [DATA_W-1:0]  exp_rd0[$];
  logic [DATA_W-1:0]  exp_rd1[$];
  bit                 gq[$];
  int                 slv_id[$];
  int                 slv_left[$];

  // Bench master state
  bit                 m_act[2];
  bit                 m_wr[2];
  int                 m_len[2];
  int                 m_done[2];
  logic [ADDR_W-1:0]  m_addr[2];
  logic [BURST_W-1:0] m_bc[2];
  logic [DATA_W-1:0]  m_wd[2];
  logic [BE_W-1:0]    m_be[2];

  int p_req[2];
  int p_wr, p_wait, p_rsp, p_urg, force_bc;
  bit resp_en, stray;
  bit last_g, err_exp, exp_idle;

  int checks, errors;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic apply_inputs();
    m0_address    = m_addr[0];
    m0_read       = m_act[0] & ~m_wr[0];
    m0_write      = m_act[0] &  m_wr[0];
    m0_burstcount = m_bc[0];
    m0_writedata  = m_wd[0];
    m0_byteenable = m_be[0];
    m1_address    = m_addr[1];
    m1_read       = m_act[1] & ~m_wr[1];
    m1_write      = m_act[1] &  m_wr[1];
    m1_burstcount = m_bc[1];
    m1_writedata  = m_wd[1];
    m1_byteenable = m_be[1];
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_wr[i] = 0; m_len[i] = 0; m_done[i] = 0;
      m_addr[i] = '0; m_bc[i] = '0; m_wd[i] = '0; m_be[i] = '0;
    end
    exp_cmd.delete(); exp_rd0.delete(); exp_rd1.delete(); gq.delete();
    slv_id.delete(); slv_left.delete();
    last_g = 1'b1; err_exp = 0; exp_idle = 0; stray = 0;
    m0_urgent = 0; s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;
    apply_inputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_outs"},
          {m0_waitrequest, m1_waitrequest, s_read, s_write,
           m0_readdatavalid, m1_readdatavalid, grant_id, rsp_err}, 9'b1_1000_0000);
    check({tag, "_cmd"}, {s_address, s_burstcount, s_byteenable}, '0);
  endtask

  // One bus cycle: slave response + master stimulus at negedge, model checks at +1.
  task automatic cycle();
    int   pend;
    bit   gv, g, req0, req1, rsp_pop, rd_g, wr_g, full, win;
    logic mw[2];
    @(negedge clk);
    rsp_pop         = 0;
    s_readdata      = {$urandom, $urandom};
    s_readdatavalid = 0;
    if (stray) begin
      s_readdatavalid = 1;
    end else if (resp_en && slv_id.size() > 0 && roll(p_rsp)) begin
      s_readdatavalid = 1;
      if (slv_id[0] == 0) exp_rd0.push_back(s_readdata);
      else                exp_rd1.push_back(s_readdata);
      if (slv_left[0] == 1) rsp_pop = 1;
      else                  slv_left[0]--;
    end
    s_waitrequest = roll(p_wait);
    for (int i = 0; i < 2; i++) begin
      if (!m_act[i] && roll(p_req[i])) begin
        m_act[i]  = 1;
        m_wr[i]   = roll(p_wr);
        m_bc[i]   = (force_bc != 0) ? BURST_W'(force_bc) : BURST_W'($urandom_range(0, 8));
        m_len[i]  = (m_bc[i] == 0) ? 1 : int'(m_bc[i]);
        m_done[i] = 0;
        m_addr[i] = ADDR_W'($urandom);
        m_wd[i]   = {$urandom, $urandom};
        m_be[i]   = BE_W'($urandom);
      end
    end
    m0_urgent = roll(p_urg);
    apply_inputs();
    #1;
    pend  = slv_id.size();
    full  = (pend == PEND_DEPTH);
    gv    = grant_id[1];
    g     = grant_id[0];
    mw[0] = m0_waitrequest;
    mw[1] = m1_waitrequest;

    check("rsp_err", rsp_err, err_exp);
    if (exp_idle) check("release_idle", gv, 0);
    exp_idle = 0;
    for (int i = 0; i < 2; i++)
      if (m_act[i] && m_wr[i] && m_done[i] > 0) check("burst_hold", grant_id, {1'b1, 1'(i)});

    if (!gv) begin
      check("idle_outs", {mw[0], mw[1], s_read, s_write}, 4'b1100);
      req0 = m_act[0];
      req1 = m_act[1];
      if (req0 || req1) begin
        if (m0_urgent && req0) win = 0;
        else if (req0 && req1) win = !last_g;
        else if (req0)         win = 0;
        else                   win = 1;
        last_g = win;
        gq.push_back(win);
      end
    end else begin
      rd_g = m_act[g] && !m_wr[g];
      wr_g = m_act[g] &&  m_wr[g];
      check("grant_outs", {mw[g], mw[!g], s_read, s_write},
            {s_waitrequest | (rd_g & full), 1'b1, rd_g & ~full, wr_g});
    end

    for (int i = 0; i < 2; i++) begin
      if (m_act[i] && !mw[i]) begin
        exp_cmd.push_back('{wr: m_wr[i], addr: m_addr[i], bc: m_bc[i], wd: m_wd[i], be: m_be[i]});
        if (!m_wr[i]) begin
          slv_id.push_back(i);
          slv_left.push_back(m_len[i]);
          m_act[i] = 0;
          exp_idle = 1;
        end else begin
          m_done[i]++;
          if (m_done[i] == m_len[i]) begin
            m_act[i] = 0;
            exp_idle = 1;
          end else begin
            m_wd[i] = {$urandom, $urandom};
            m_be[i] = BE_W'($urandom);
          end
        end
      end
    end
    if (s_readdatavalid && pend == 0) err_exp = 1;
    if (rsp_pop) begin
      void'(slv_id.pop_front());
      void'(slv_left.pop_front());
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a slave command, read beat or new grant.
  initial begin
    bit   prev_gv, gq_old;
    cmd_t e;
    prev_gv = 0;
    gq_old  = 0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_gv = 0;
        gq_old  = 0;
      end else begin
        if ((s_read || s_write) && !s_waitrequest) begin
          if (exp_cmd.size() == 0) check("slave_cmd_unexpected", 1, 0);
          else begin
            e = exp_cmd.pop_front();
            check("slave_cmd", {s_write, s_address, s_burstcount, s_writedata, s_byteenable}, e);
          end
        end
        if (m0_readdatavalid) begin
          if (exp_rd0.size() == 0) check("m0_rdv_unexpected", 1, 0);
          else check("m0_rdata", m0_readdata, exp_rd0.pop_front());
        end
        if (m1_readdatavalid) begin
          if (exp_rd1.size() == 0) check("m1_rdv_unexpected", 1, 0);
          else check("m1_rdata", m1_readdata, exp_rd1.pop_front());
        end
        if (s_readdatavalid) check("rdv_delivered", exp_rd0.size() + exp_rd1.size(), 0);
        if (grant_id[1] && !prev_gv) begin
          if (gq.size() == 0) check("grant_unexpected", 1, 0);
          else check("grant_winner", grant_id[0], gq.pop_front());
        end else if (gq.size() > 0 && gq_old) begin
          check("grant_latency", grant_id[1], 1);
          gq.delete();
        end
        prev_gv = grant_id[1];
        gq_old  = (gq.size() > 0);
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    p_req[0] = 0; p_req[1] = 0;
    resp_en = 1; p_rsp = 100; p_wait = 0; p_urg = 0;
    n = 0;
    while ((m_act[0] || m_act[1] || slv_id.size() > 0) && n < 200) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, {m_act[0], m_act[1], slv_id.size() == 0}, 3'b001);
    repeat (2) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    p_req[0] = 0; p_req[1] = 0;
    p_wr = 0; p_wait = 0; p_rsp = 0; p_urg = 0; force_bc = 0; resp_en = 1;
    reset = 1;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 0;

    // Mixed random traffic with waitstates, urgent and random response timing
    p_req[0] = 60; p_req[1] = 60; p_wr = 50; p_wait = 25; p_rsp = 60; p_urg = 20;
    repeat (800) cycle();

    // Continuous reads from both: round-robin alternation
    p_req[0] = 100; p_req[1] = 100; p_wr = 0; p_wait = 0; p_urg = 0; p_rsp = 70;
    repeat (60) cycle();

    // Camera urgent held: m0 wins every tie
    p_urg = 100;
    repeat (40) cycle();
    drain("mix");

    // Fill the pending FIFO with bc=2 reads while responses are withheld
    p_req[0] = 100; p_req[1] = 0; p_wr = 0; p_wait = 0; p_urg = 0; force_bc = 2; resp_en = 0;
    repeat (30) cycle();
    check("fifo_filled", slv_id.size(), PEND_DEPTH);
    check("ninth_stalled", {m0_read, m0_waitrequest, s_read}, 3'b110);
    resp_en = 1; p_rsp = 100;
    repeat (30) cycle();
    force_bc = 0;
    drain("fifo");

    // Orphan read beat
    stray = 1;
    cycle();
    stray = 0;
    repeat (2) cycle();
    check("rsp_err_sticky", rsp_err, 1);

    // Reset in the middle of an 8-beat write
    p_req[0] = 100; p_req[1] = 0; p_wr = 100; p_wait = 0; force_bc = 8;
    n = 0;
    while (!(m_act[0] && m_wr[0] && m_done[0] >= 3) && n < 40) begin
      cycle();
      n++;
    end
    check("midwrite_reached", m_done[0] >= 3, 1);
    @(negedge clk);
    reset = 1;
    #1;
    check_reset_values("midwrite_reset");
    clear_model();
    p_req[0] = 0; force_bc = 0;
    repeat (2) @(negedge clk);
    reset = 0;

    // Traffic resumes cleanly after reset
    p_req[0] = 50; p_req[1] = 50; p_wr = 50; p_wait = 20; p_rsp = 50; p_urg = 10;
    repeat (200) cycle();
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
